// File: rtl/ethernet_system_descriptor_walker.sv
// Avalon-MM master that walks a linked list of 4-word DMA descriptors, hands owned
// descriptors to a packet engine, and writes completion status back with OWN cleared.
module ethernet_system_descriptor_walker #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic              stop,
  output logic              busy,
  output logic              chain_end,
  output logic [15:0]       desc_count,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              m_clken,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [DATA_W-1:0] desc_buffer,
  output logic [15:0]       desc_length,
  output logic              desc_eop,
  input  logic              done_valid,
  input  logic [7:0]        done_status
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LAST, CHECK, PRESENT, WAIT_DONE, WRITEBACK
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] next_ptr;
  logic [1:0]        word_idx;
  logic              own;
  logic              stop_pend;

  // Word k of a descriptor lives in the low two address bits; no carry into the base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0]        k);
    return (base & {{(ADDR_W-2){1'b1}}, 2'b00}) | {{(ADDR_W-2){1'b0}}, k};
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cur          <= '0;
      next_ptr     <= '0;
      word_idx     <= '0;
      own          <= 1'b0;
      stop_pend    <= 1'b0;
      chain_end    <= 1'b0;
      desc_count   <= '0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_clken      <= 1'b0;
      desc_valid   <= 1'b0;
      desc_buffer  <= '0;
      desc_length  <= '0;
      desc_eop     <= 1'b0;
    end else begin
      m_clken   <= 1'b1;
      chain_end <= 1'b0;
      if (stop && state != IDLE) stop_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cur          <= word_addr(head_ptr, 2'd0);
            desc_count   <= '0;
            stop_pend    <= 1'b0;
            word_idx     <= 2'd0;
            m_address    <= word_addr(head_ptr, 2'd0);
            m_chipselect <= 1'b1;
            m_write      <= 1'b0;
            m_byteenable <= 4'hF;
            state        <= FETCH;
          end
        end
        FETCH: begin
          // Read data on the bus belongs to the word issued one cycle earlier.
          case (word_idx)
            2'd1:    next_ptr    <= word_addr(m_readdata[ADDR_W-1:0], 2'd0);
            2'd2:    desc_buffer <= m_readdata;
            2'd3:    desc_length <= m_readdata[15:0];
            default: ;
          endcase
          if (word_idx == 2'd3) begin
            m_chipselect <= 1'b0;
            state        <= LAST;
          end else begin
            word_idx  <= word_idx + 2'd1;
            m_address <= word_addr(cur, word_idx + 2'd1);
          end
        end
        LAST: begin
          own       <= m_readdata[31];
          desc_eop  <= m_readdata[30];
          chain_end <= ~m_readdata[31];
          state     <= CHECK;
        end
        CHECK: begin
          if (own) begin
            desc_valid <= 1'b1;
            state      <= PRESENT;
          end else begin
            state <= IDLE;
          end
        end
        PRESENT: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_valid) begin
            m_address    <= word_addr(cur, 2'd3);
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_byteenable <= 4'b1001;
            m_writedata  <= {{(DATA_W-8){1'b0}}, done_status};
            state        <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          desc_count <= desc_count + 16'd1;
          m_write    <= 1'b0;
          if (stop_pend || stop) begin
            m_chipselect <= 1'b0;
            state        <= IDLE;
          end else begin
            cur          <= next_ptr;
            m_address    <= next_ptr;
            m_byteenable <= 4'hF;
            word_idx     <= 2'd0;
            state        <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_system_descriptor_walker.sv
// Scoreboard bench for the descriptor walker: a behavioural memory and downstream
// engine surround the DUT; a monitor checks presentations, writebacks and chain ends.
module tb_ethernet_system_descriptor_walker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] head_ptr = '0;
  logic        stop = 1'b0;
  logic        busy, chain_end;
  logic [15:0] desc_count;
  logic [10:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_clken, desc_valid;
  logic        desc_ready = 1'b1;
  logic [31:0] desc_buffer;
  logic [15:0] desc_length;
  logic        desc_eop;
  logic        done_valid;
  logic [7:0]  done_status = '0;
  logic        auto_dv = 1'b0;
  logic        manual_dv = 1'b0;

  assign done_valid = auto_dv | manual_dv;

  ethernet_system_descriptor_walker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .head_ptr(head_ptr), .stop(stop),
    .busy(busy), .chain_end(chain_end), .desc_count(desc_count),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_clken(m_clken), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_buffer(desc_buffer), .desc_length(desc_length), .desc_eop(desc_eop),
    .done_valid(done_valid), .done_status(done_status)
  );

  always #5 clk = ~clk;

  // Descriptor memory: 1-cycle read latency, byte-lane writes, plus a bench load port.
  logic [31:0] mem [0:2047];
  logic        tb_we = 1'b0;
  logic [10:0] tb_addr = '0;
  logic [31:0] tb_data = '0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (m_chipselect) begin
      if (m_write) begin
        for (int i = 0; i < 4; i++)
          if (m_byteenable[i]) mem[m_address][8*i +: 8] <= m_writedata[8*i +: 8];
      end else begin
        m_readdata <= mem[m_address];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int kind; logic [31:0] a; logic [31:0] b; logic [31:0] c; } ev_t;
  localparam int EV_PRESENT = 1, EV_WRITE = 2, EV_END = 3;
  ev_t        exp_q[$];
  logic [7:0] stat_q[$];

  task automatic push_ev(input int kind, input logic [31:0] a, b, c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] a, b, c);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind=%0d a=%h b=%h c=%h, required no event", kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        n_bad++;
        $display("FAIL sb_event: got kind=%0d a=%h b=%h c=%h, required kind=%0d a=%h b=%h c=%h",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: every observable DUT event is matched against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (desc_valid && desc_ready)
          sb_check(EV_PRESENT, desc_buffer, {16'd0, desc_length}, {31'd0, desc_eop});
        if (m_chipselect && m_write)
          sb_check(EV_WRITE, {21'd0, m_address}, {28'd0, m_byteenable}, m_writedata);
        if (chain_end) sb_check(EV_END, 32'd0, 32'd0, 32'd0);
      end
    end
  end

  // Downstream engine: completes each accepted descriptor on the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && desc_valid && desc_ready) begin
        @(posedge clk); #1;
        done_status = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
        auto_dv = 1'b1;
        @(posedge clk); #1;
        auto_dv = 1'b0;
      end
    end
  end

  task automatic poke(input logic [10:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    tb_addr = addr; tb_data = data; tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic put_desc(input logic [10:0] b, input logic [31:0] w0, w1, w2, w3);
    poke(b, w0); poke(b | 11'd1, w1); poke(b | 11'd2, w2); poke(b | 11'd3, w3);
  endtask

  // Leaves the bench #1 after the edge that sampled start (cycle 1).
  task automatic do_start(input logic [10:0] ptr);
    @(posedge clk); #1;
    start = 1'b1; head_ptr = ptr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!desc_valid && n < budget) begin @(posedge clk); #1; n++; end
    check(name, {63'd0, desc_valid}, 64'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_zero(input string name);
    check(name, {busy, chain_end, desc_valid, m_chipselect, m_write, m_clken, desc_eop,
                 m_byteenable, m_address, desc_length, desc_count}, 64'd0);
    check({name, "_data"}, {m_writedata, desc_buffer}, 64'd0);
  endtask

  initial begin
    logic ok;

    // Reset state and clock-enable release
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("clken_after_reset", {63'd0, m_clken}, 64'd1);

    // Single self-linked descriptor
    put_desc(11'h010, 32'h0000_0010, 32'h1234_5678, 32'h0000_05EE, 32'hC000_0000);
    stat_q.push_back(8'h5A);
    push_ev(EV_PRESENT, 32'h1234_5678, 32'd1518, 32'd1);
    push_ev(EV_WRITE, 32'h013, 32'h9, 32'h0000_005A);
    push_ev(EV_END, 0, 0, 0);
    do_start(11'h010);
    check("first_read", {m_chipselect, m_write, m_byteenable, m_address}, {1'b1, 1'b0, 4'hF, 11'h010});
    repeat (5) @(posedge clk);
    #1 check("valid_not_early", {63'd0, desc_valid}, 64'd0);
    @(posedge clk); #1;
    check("valid_cycle7", {63'd0, desc_valid}, 64'd1);
    wait_idle("t1_idle", 60);
    check("t1_count", {48'd0, desc_count}, 64'd1);
    check("t1_mem_w3", {32'd0, mem[11'h013]}, 64'h5A);
    check("t1_sb_empty", exp_q.size(), 0);

    // Three-link chain ending at a non-owned descriptor at 2044
    put_desc(11'h000, 32'h0000_0004, 32'hAAAA_0000, 32'h0000_0040, 32'h8000_0000);
    put_desc(11'h004, 32'h0000_07FC, 32'hBBBB_0004, 32'h0000_0100, 32'hC000_0011);
    put_desc(11'h7FC, 32'h0000_0000, 32'hCCCC_0000, 32'h0000_0001, 32'h0000_0000);
    stat_q.push_back(8'h01); stat_q.push_back(8'h02);
    push_ev(EV_PRESENT, 32'hAAAA_0000, 32'd64, 32'd0);
    push_ev(EV_WRITE, 32'h003, 32'h9, 32'h01);
    push_ev(EV_PRESENT, 32'hBBBB_0004, 32'd256, 32'd1);
    push_ev(EV_WRITE, 32'h007, 32'h9, 32'h02);
    push_ev(EV_END, 0, 0, 0);
    do_start(11'h000);
    wait_idle("t2_idle", 100);
    check("t2_count", {48'd0, desc_count}, 64'd2);
    check("t2_mem_w7", {32'd0, mem[11'h007]}, 64'h0000_0002);
    check("t2_sb_empty", exp_q.size(), 0);

    // Backpressure: fields stable and memory quiet while desc_ready is low
    put_desc(11'h100, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0040, 32'h8000_0000);
    stat_q.push_back(8'h33);
    push_ev(EV_PRESENT, 32'hDEAD_BEEF, 32'd64, 32'd0);
    push_ev(EV_WRITE, 32'h103, 32'h9, 32'h33);
    push_ev(EV_END, 0, 0, 0);
    desc_ready = 1'b0;
    do_start(11'h101);
    wait_valid("t3_valid", 20);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!desc_valid || desc_buffer != 32'hDEAD_BEEF || desc_length != 16'd64 ||
          desc_eop || m_chipselect) ok = 1'b0;
    end
    check("t3_stable", {63'd0, ok}, 64'd1);
    desc_ready = 1'b1;
    wait_idle("t3_idle", 60);
    check("t3_sb_empty", exp_q.size(), 0);

    // stop during the first presentation of an owned chain
    put_desc(11'h200, 32'h0000_0204, 32'h0000_2000, 32'h0000_0010, 32'hC000_0000);
    put_desc(11'h204, 32'h0000_0208, 32'h0000_2040, 32'h0000_0020, 32'h8000_0000);
    put_desc(11'h208, 32'h0000_0208, 32'h0000_2080, 32'h0000_0030, 32'h8000_0000);
    stat_q.push_back(8'h44);
    push_ev(EV_PRESENT, 32'h0000_2000, 32'd16, 32'd1);
    push_ev(EV_WRITE, 32'h203, 32'h9, 32'h44);
    desc_ready = 1'b0;
    do_start(11'h200);
    wait_valid("t4_valid", 20);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    desc_ready = 1'b1;
    wait_idle("t4_idle", 30);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_chipselect || busy) ok = 1'b0;
    end
    check("t4_quiet", {63'd0, ok}, 64'd1);
    check("t4_count", {48'd0, desc_count}, 64'd1);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a writeback, then restart
    put_desc(11'h300, 32'h0000_0300, 32'h0000_3000, 32'h0000_0008, 32'h8000_0000);
    stat_q.push_back(8'h66);
    push_ev(EV_PRESENT, 32'h0000_3000, 32'd8, 32'd0);
    do_start(11'h300);
    begin
      int n = 0;
      while (!(m_chipselect && m_write) && n < 30) begin @(posedge clk); #1; n++; end
    end
    check("t5_in_writeback", {63'd0, m_write}, 64'd1);
    reset_n = 1'b0;
    #1 check_zero("t5_reset");
    check("t5_sb_empty", exp_q.size(), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    stat_q.push_back(8'h77);
    push_ev(EV_PRESENT, 32'h0000_3000, 32'd8, 32'd0);
    push_ev(EV_WRITE, 32'h303, 32'h9, 32'h77);
    push_ev(EV_END, 0, 0, 0);
    do_start(11'h300);
    check("t5_count_cleared", {48'd0, desc_count}, 64'd0);
    wait_idle("t5_idle", 60);
    check("t5_count", {48'd0, desc_count}, 64'd1);
    check("t5_sb_empty2", exp_q.size(), 0);

    // start and done_valid while fetching are both ignored
    put_desc(11'h400, 32'h0000_0400, 32'h0000_4000, 32'h0000_0080, 32'hC000_0000);
    stat_q.push_back(8'h88);
    push_ev(EV_PRESENT, 32'h0000_4000, 32'd128, 32'd1);
    push_ev(EV_WRITE, 32'h403, 32'h9, 32'h88);
    push_ev(EV_END, 0, 0, 0);
    do_start(11'h400);
    @(posedge clk); #1;
    start = 1'b1; head_ptr = 11'h010; manual_dv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; manual_dv = 1'b0;
    wait_idle("t6_idle", 60);
    check("t6_count", {48'd0, desc_count}, 64'd1);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
